// File: rtl/int8_dot_pkg.sv
// int8_dot_pkg: shared FSM states, default widths and saturation limits for the INT8 dot-product block
package int8_dot_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_e;
  localparam int DEF_LEN_W = 8;
  localparam int DEF_ACC_W = 32;
  localparam logic signed [DEF_ACC_W-1:0] SAT_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic signed [DEF_ACC_W-1:0] SAT_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};
endpackage

// File: rtl/int8_dot_if.sv
// int8_dot_if: job control, operand stream and result stream of the INT8 dot-product sequencer
// master: drives start/len/abort, in_valid/a/b, res_ready; slave: drives busy, in_ready, res_valid/result/ovf
interface int8_dot_if
  import int8_dot_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int ACC_W = DEF_ACC_W
);
  logic start;
  logic [LEN_W-1:0] len;
  logic abort;
  logic busy;
  logic in_valid;
  logic in_ready;
  logic signed [7:0] a;
  logic signed [7:0] b;
  logic res_valid;
  logic res_ready;
  logic signed [ACC_W-1:0] result;
  logic ovf;
  modport master (
    output start, len, abort, in_valid, a, b, res_ready,
    input  busy, in_ready, res_valid, result, ovf
  );
  modport slave (
    input  start, len, abort, in_valid, a, b, res_ready,
    output busy, in_ready, res_valid, result, ovf
  );
endinterface

// File: rtl/int8_dot_acc.sv
// int8_dot_acc: product register plus accumulator for signed INT8 pairs
// clk/rst: clock, async active-high reset; clr_i: zero accumulator, pipeline and ovf;
// kill_i: drop the in-flight product; beat_i/a_i/b_i: accepted pair; acc_o: accumulator; ovf_o: sticky clamp flag
// INT8_DOT_SAT_EN: saturate at the signed ACC_W limits instead of wrapping
module int8_dot_acc
  import int8_dot_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    kill_i,
  input  logic                    beat_i,
  input  logic signed [7:0]       a_i,
  input  logic signed [7:0]       b_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic                    ovf_o
);
  logic signed [15:0] prod_q, prod_d;
  logic prod_vld_q, prod_vld_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W:0] sum;
  assign sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_q);
  assign acc_o = acc_q;
`ifdef INT8_DOT_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic ovf_q, ovf_d, clip;
  // one guard bit: the add overflowed when it disagrees with the sign bit
  assign clip = sum[ACC_W] != sum[ACC_W-1];
  always_comb begin
    acc_d = clr_i ? '0 : !prod_vld_q ? acc_q : !clip ? sum[ACC_W-1:0] : sum[ACC_W] ? ACC_MIN : ACC_MAX;
    ovf_d = clr_i ? 1'b0 : ovf_q | (prod_vld_q & clip);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  assign ovf_o = ovf_q;
`else
  always_comb acc_d = clr_i ? '0 : prod_vld_q ? sum[ACC_W-1:0] : acc_q;
  assign ovf_o = 1'b0;
`endif
  always_comb begin
    prod_d     = beat_i ? 16'(a_i) * 16'(b_i) : prod_q;
    prod_vld_d = beat_i & ~kill_i;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
    end
endmodule

// File: rtl/int8_dot_ctrl.sv
// int8_dot_ctrl: job sequencer for signed INT8 dot products over valid/ready streams
// clk/rst: clock, async active-high reset; bus_io (slave): start/len/abort/busy, in_valid/in_ready/a/b,
// res_valid/res_ready/result/ovf
// INT8_DOT_SAT_EN: saturating accumulator with sticky ovf (otherwise wraps, ovf tied low)
module int8_dot_ctrl
  import int8_dot_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input logic        clk,
  input logic        rst,
  int8_dot_if.slave  bus_io
);
  state_e state_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic busy_q, in_ready_q, res_valid_q;
  logic beat, last, clr, kill;
  assign beat = bus_io.in_valid & in_ready_q;
  assign last = cnt_q == len_q - 1'b1;
  assign clr  = (state_q == IDLE) & bus_io.start;
  assign kill = bus_io.abort & (state_q != IDLE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else if (kill) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus_io.start) begin
          len_q       <= bus_io.len;
          cnt_q       <= '0;
          busy_q      <= 1'b1;
          in_ready_q  <= bus_io.len != '0;
          res_valid_q <= bus_io.len == '0;
          state_q     <= bus_io.len != '0 ? RUN : OUT;
        end
        RUN: if (beat) begin
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q    <= FLUSH;
            in_ready_q <= 1'b0;
          end
        end
        FLUSH: begin
          state_q     <= OUT;
          res_valid_q <= 1'b1;
        end
        OUT: if (bus_io.res_ready) begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus_io.busy      = busy_q;
  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.res_valid = res_valid_q;
  int8_dot_acc #(.ACC_W(ACC_W)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .kill_i (kill),
    .beat_i (beat),
    .a_i    (bus_io.a),
    .b_i    (bus_io.b),
    .acc_o  (bus_io.result),
    .ovf_o  (bus_io.ovf)
  );
endmodule

// File: doc/int8_dot_ctrl.md
# int8_dot_ctrl

Sequencer for signed INT8 dot products in the ML datapath. It accepts a job of length `len`, then pulls `len` operand pairs over a valid/ready stream. Each pair feeds a two-stage multiply/accumulate pipeline. The 32-bit sum is presented on a valid/ready result port. Upstream is the operand fetch unit; downstream is the writeback/activation stage.

## Interface
Parameters:
- `LEN_W`, default 8: width of the job length; max job length 2^LEN_W−1.
- `ACC_W`, default 32: accumulator and result width; must be ≥ 16+LEN_W.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  LEN_W  number of operand pairs; sampled with `start`.
- `abort`  in  1  synchronous job cancel.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  controller accepts a pair this cycle.
- `a`  in  8  signed INT8 operand A.
- `b`  in  8  signed INT8 operand B.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `result`  out  ACC_W  signed dot product.
- `ovf`  out  1  sticky saturation flag for the current job.

## Operation
- Reset values:
  - state = IDLE; `busy`, `in_ready`, `res_valid` and `ovf` = 0.
  - `result`, accumulator, product register, `prod_vld` and beat counter = 0.
- States:
  - IDLE: `start`=1 and `len`≠0 → RUN. The accumulator, counter and `ovf` clear at this edge, and `len` is latched. `start`=1 and `len`=0 → OUT with result 0.
  - RUN: `in_ready`=1. Each beat (`in_valid`&`in_ready`) registers the product `a*b` (16-bit signed) and increments the counter. The beat with counter = len−1 → FLUSH.
  - FLUSH: `in_ready`=0. The final pending product is added → OUT.
  - OUT: `res_valid`=1 and `result` is held stable. `res_ready`=1 → IDLE.
- Pipeline:
  - Every cycle in which `prod_vld`=1, the accumulator gains the sign-extended product.
  - `prod_vld` is the registered beat indication.
- `result` is driven from the accumulator and is meaningful only while `res_valid`=1.
- `start` outside IDLE is ignored, with no queuing.
- `abort`=1 in any non-IDLE state → IDLE at the next edge, with `prod_vld` cleared and no result produced. `abort` has priority over all other transitions. In IDLE, `abort` is ignored.
- An `in_valid` gap in RUN stalls the job; there is no timeout.
- Asserting `rst` mid-job immediately returns all state to the reset values.

## Timing
- `start` accepted at edge 0 → `in_ready`=1 in cycle 1.
- Last beat in cycle t → FLUSH in t+1 → `res_valid`=1 from cycle t+2.
- Minimum job (len=1, back-to-back): `start` in cycle 0, beat in cycle 1, `res_valid` in cycle 3.
- len=0: `res_valid`=1 in cycle 1.
- Throughput: one pair per cycle in RUN.
- Job overhead: `len`+3 cycles including the result handshake, when `res_ready` is held high.
- The earliest next `start` is accepted in the cycle after the result handshake (the IDLE cycle).

## Configuration
- `INT8_DOT_SAT_EN` defined:
  - The accumulator saturates to the signed ACC_W limits (max 2^(ACC_W−1)−1, min −2^(ACC_W−1)).
  - `ovf` sets on any clamp and holds until the next accepted `start`.
- Not defined:
  - The accumulator wraps modulo 2^ACC_W.
  - `ovf` is tied to 0; the port remains present.

## Structure
- Shared package `int8_dot_pkg` holds:
  - the state enum (IDLE, RUN, FLUSH, OUT);
  - the default `ACC_W`/`LEN_W` constants;
  - the saturation limit constants.
- Sub-module `int8_dot_acc` holds the product register, `prod_vld`, the accumulator add and the optional saturation logic, with a clear input.
- The FSM, counter and handshakes live in the top module.

## Test plan
- Basic job:
  - Stimulus: len=4; pairs (1,2), (−3,4), (127,127), (−128,−128); `res_ready` held high.
  - Required: `result` = 2−12+16129+16384 = 32503, with `res_valid` 2 cycles after the last beat.
- len=0:
  - Stimulus: `start` with len=0.
  - Required: `res_valid` in cycle 1, `result`=0, `in_ready` never asserted.
- Backpressure and gaps:
  - Stimulus: len=3 with `in_valid` gaps, then `res_ready` held low for 5 cycles.
  - Required: result correct and held stable; no new `start` accepted until after the handshake.
- Abort:
  - Stimulus: `abort` after 2 beats of a len=5 job.
  - Required: IDLE next cycle, no `res_valid`. A following len=1 job (5,5) yields 25.
- Async reset mid-RUN:
  - Stimulus: assert `rst` while in RUN.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
- Saturation (with `INT8_DOT_SAT_EN`, ACC_W=32):
  - Stimulus: 255 pairs of (−128,−128), repeated over jobs with a preloaded accumulator via `force`.
  - Required: clamp at 2147483647 and `ovf`=1.
- Wrap (without `INT8_DOT_SAT_EN`):
  - Stimulus: same as the saturation case.
  - Required: result wraps and `ovf`=0.
